// File: rtl/exbus_arb.sv
// rtl/exbus_arb.sv - packet-aware round-robin arbiter merging two exbus word sources
module exbus_arb #(
   parameter int LGBURST = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_a_stb,
   input  logic [34:0] i_a_word,
   input  logic        i_a_last,
   output logic        o_a_busy,
   input  logic        i_b_stb,
   input  logic [34:0] i_b_word,
   input  logic        i_b_last,
   output logic        o_b_busy,
   output logic        o_stb,
   output logic [34:0] o_word,
   output logic        o_src,
   input  logic        i_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } gstate_t;

   gstate_t              gstate_q, gstate_d;
   logic                 rr_q, rr_d;
   logic [LGBURST-1:0]   bcnt_q, bcnt_d;
   logic                 o_stb_q, o_stb_d;
   logic [34:0]          o_word_q, o_word_d;
   logic                 o_src_q, o_src_d;

   logic                 ordy;
   logic                 acc_a;
   logic                 acc_b;
   logic                 bcnt_max;

   // Output register can take a word when empty or when downstream is draining it.
   always_comb begin
      ordy     = !o_stb_q || !i_busy;
      acc_a    = (gstate_q == GNT_A) && i_a_stb && ordy;
      acc_b    = (gstate_q == GNT_B) && i_b_stb && ordy;
      bcnt_max = &bcnt_q;
   end

   assign o_a_busy = !acc_a;
   assign o_b_busy = !acc_b;
   assign o_stb    = o_stb_q;
   assign o_word   = o_word_q;
   assign o_src    = o_src_q;

   // Grant selection, burst counting and output word capture.
   always_comb begin
      gstate_d = gstate_q;
      rr_d     = rr_q;
      bcnt_d   = bcnt_q;
      o_stb_d  = o_stb_q;
      o_word_d = o_word_q;
      o_src_d  = o_src_q;

      // Downstream took the word and nothing new replaces it.
      if (!acc_a && !acc_b && !i_busy) begin
         o_stb_d = 1'b0;
      end

      case (gstate_q)
         IDLE: begin
            // A wins when alone or when it holds the round-robin preference.
            if (i_a_stb && (!i_b_stb || !rr_q)) begin
               gstate_d = GNT_A;
               bcnt_d   = '0;
            end else if (i_b_stb) begin
               gstate_d = GNT_B;
               bcnt_d   = '0;
            end
         end
         GNT_A: begin
            if (acc_a) begin
               o_word_d = i_a_word;
               o_src_d  = 1'b0;
               o_stb_d  = 1'b1;
               bcnt_d   = bcnt_q + 1'b1;
               if (i_a_last || bcnt_max) begin
                  gstate_d = IDLE;
                  rr_d     = 1'b1;
               end
            end else if (!i_a_stb) begin
               // A gap in the source ends its grant at once.
               gstate_d = IDLE;
               rr_d     = 1'b1;
            end
         end
         GNT_B: begin
            if (acc_b) begin
               o_word_d = i_b_word;
               o_src_d  = 1'b1;
               o_stb_d  = 1'b1;
               bcnt_d   = bcnt_q + 1'b1;
               if (i_b_last || bcnt_max) begin
                  gstate_d = IDLE;
                  rr_d     = 1'b0;
               end
            end else if (!i_b_stb) begin
               gstate_d = IDLE;
               rr_d     = 1'b0;
            end
         end
         default: begin
            gstate_d = IDLE;
         end
      endcase
   end

   // State register; reset abandons any grant and drops the pending word.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         gstate_q <= IDLE;
         rr_q     <= 1'b0;
         bcnt_q   <= '0;
         o_stb_q  <= 1'b0;
         o_word_q <= '0;
         o_src_q  <= 1'b0;
      end else begin
         gstate_q <= gstate_d;
         rr_q     <= rr_d;
         bcnt_q   <= bcnt_d;
         o_stb_q  <= o_stb_d;
         o_word_q <= o_word_d;
         o_src_q  <= o_src_d;
      end
   end

endmodule

// File: tb/tb_exbus_arb.sv
// tb/tb_exbus_arb.sv - scoreboard bench for exbus_arb with directed and random traffic
module tb_exbus_arb;

   localparam int LG    = 2;
   localparam int BURST = 1 << LG;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_a_stb, i_a_last, o_a_busy;
   logic [34:0] i_a_word;
   logic        i_b_stb, i_b_last, o_b_busy;
   logic [34:0] i_b_word;
   logic        o_stb, o_src, i_busy;
   logic [34:0] o_word;

   exbus_arb #(.LGBURST(LG)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_a_stb(i_a_stb), .i_a_word(i_a_word), .i_a_last(i_a_last), .o_a_busy(o_a_busy),
      .i_b_stb(i_b_stb), .i_b_word(i_b_word), .i_b_last(i_b_last), .o_b_busy(o_b_busy),
      .o_stb(o_stb), .o_word(o_word), .o_src(o_src), .i_busy(i_busy)
   );

   initial forever #5 i_clk = ~i_clk;

   typedef struct {
      logic [34:0] w;
      logic        l;
      logic        g;
   } ent_t;

   ent_t        qa[$], qb[$];
   logic [34:0] exp_a[$], exp_b[$];
   logic        src_log[$];
   int          errs = 0;
   int          checks = 0;
   int          seq = 0;
   bit          rand_mode = 0;
   bit          busy_force = 0;
   int          run_a = 0, run_b = 0;
   logic        acc_a_n, acc_b_n;
   logic        prev_hold = 1'b0;
   logic [34:0] prev_word;
   logic        prev_src;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic push_pkt(input bit src, input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         ent_t e;
         seq++;
         e.w = {2'($urandom_range(0, 3)), src, 32'(seq)};
         e.l = with_last && (i == n - 1);
         e.g = 1'b0;
         if (src) qb.push_back(e);
         else     qa.push_back(e);
      end
   endtask

   task automatic chk_log(input string nm, input logic e[$]);
      chk({nm, "_len"}, 64'(src_log.size()), 64'(e.size()));
      for (int i = 0; i < e.size() && i < src_log.size(); i++)
         chk($sformatf("%s_src%0d", nm, i), 64'(src_log[i]), 64'(e[i]));
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while (n < 400 && !(qa.size() == 0 && qb.size() == 0 && exp_a.size() == 0 &&
                          exp_b.size() == 0 && !o_stb && dut.gstate_q == 2'd0)) begin
         @(negedge i_clk);
         n++;
      end
      chk({nm, "_drain"}, 64'(n < 400), 64'd1);
   endtask

   // Source drivers plus output monitor; inputs change 1 unit after the edge,
   // handshakes and outputs are sampled on the falling edge.
   initial begin
      i_a_stb = 0; i_a_word = '0; i_a_last = 0;
      i_b_stb = 0; i_b_word = '0; i_b_last = 0;
      i_busy = 0;
      forever begin
         @(negedge i_clk);
         acc_a_n = i_a_stb && !o_a_busy && !i_reset;
         acc_b_n = i_b_stb && !o_b_busy && !i_reset;
         if (!i_reset) begin
            if (prev_hold) begin
               chk("hold_stb", 64'(o_stb), 64'd1);
               chk("hold_word", 64'(o_word), 64'(prev_word));
               chk("hold_src", 64'(o_src), 64'(prev_src));
            end
            if (acc_a_n || acc_b_n) chk("single_accept", 64'(acc_a_n && acc_b_n), 64'd0);
            if (!o_a_busy) chk("a_acc_needs_stb", 64'(i_a_stb), 64'd1);
            if (!o_b_busy) chk("b_acc_needs_stb", 64'(i_b_stb), 64'd1);
            if (acc_a_n) begin run_a++; chk("burst_run_a", 64'(run_a <= BURST), 64'd1); end
            else run_a = 0;
            if (acc_b_n) begin run_b++; chk("burst_run_b", 64'(run_b <= BURST), 64'd1); end
            else run_b = 0;
         end
         if (o_stb && !i_busy) begin
            src_log.push_back(o_src);
            if (!o_src) begin
               chk("word_a_expected", 64'(exp_a.size() > 0), 64'd1);
               if (exp_a.size() > 0) chk("word_a", 64'(o_word), 64'(exp_a.pop_front()));
            end else begin
               chk("word_b_expected", 64'(exp_b.size() > 0), 64'd1);
               if (exp_b.size() > 0) chk("word_b", 64'(o_word), 64'(exp_b.pop_front()));
            end
         end
         prev_hold = o_stb && i_busy && !i_reset;
         prev_word = o_word;
         prev_src  = o_src;

         @(posedge i_clk);
         #1;
         if (acc_a_n && qa.size() > 0) begin exp_a.push_back(qa[0].w); qa.delete(0); end
         if (acc_b_n && qb.size() > 0) begin exp_b.push_back(qb[0].w); qb.delete(0); end
         if (qa.size() > 0 && qa[0].g) begin
            i_a_stb = 0; qa.delete(0);
         end else if (qa.size() > 0 && !(rand_mode && $urandom_range(0, 5) == 0)) begin
            i_a_stb = 1; i_a_word = qa[0].w; i_a_last = qa[0].l;
         end else begin
            i_a_stb = 0;
         end
         if (qb.size() > 0 && qb[0].g) begin
            i_b_stb = 0; qb.delete(0);
         end else if (qb.size() > 0 && !(rand_mode && $urandom_range(0, 5) == 0)) begin
            i_b_stb = 1; i_b_word = qb[0].w; i_b_last = qb[0].l;
         end else begin
            i_b_stb = 0;
         end
         i_busy = busy_force || (rand_mode && $urandom_range(0, 3) == 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Directed scenarios followed by a randomized soak.
   initial begin
      logic e[$];
      bit   p1[6]  = '{0, 0, 1, 1, 1, 0};
      bit   p2[8]  = '{0, 0, 1, 1, 0, 1, 1, 0};
      ent_t g;
      int   n;

      repeat (3) @(negedge i_clk);
      chk("rst_o_stb", 64'(o_stb), 64'd0);
      chk("rst_o_word", 64'(o_word), 64'd0);
      chk("rst_o_src", 64'(o_src), 64'd0);
      chk("rst_gstate", 64'(dut.gstate_q), 64'd0);
      chk("rst_rr", 64'(dut.rr_q), 64'd0);
      chk("rst_bcnt", 64'(dut.bcnt_q), 64'd0);
      chk("rst_a_busy", 64'(o_a_busy), 64'd1);
      chk("rst_b_busy", 64'(o_b_busy), 64'd1);
      @(posedge i_clk); #1 i_reset = 0;

      // Single A packet: output valid for 3 cycles, 2 cycles after first stb.
      @(negedge i_clk);
      push_pkt(0, 3, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         chk($sformatf("t1_stb_c%0d", i + 1), 64'(o_stb), 64'(p1[i]));
      end
      chk("t1_gstate_idle", 64'(dut.gstate_q), 64'd0);
      wait_drain("t1");

      // Contention from reset release: A, A, gap, B, B.
      @(posedge i_clk); #1 i_reset = 1;
      @(negedge i_clk);
      push_pkt(0, 2, 1);
      push_pkt(1, 2, 1);
      @(posedge i_clk);
      @(posedge i_clk); #1 i_reset = 0;
      src_log.delete();
      for (int i = 0; i < 8; i++) begin
         @(negedge i_clk);
         chk($sformatf("t2_stb_c%0d", i), 64'(o_stb), 64'(p2[i]));
      end
      wait_drain("t2");
      e = '{0, 0, 1, 1};
      chk_log("t2", e);
      chk("t2_rr", 64'(dut.rr_q), 64'd0);

      // Burst limit: A streams 10 unterminated words against two B packets.
      @(negedge i_clk);
      src_log.delete();
      push_pkt(0, 10, 0);
      push_pkt(1, 3, 1);
      push_pkt(1, 3, 1);
      wait_drain("t3");
      e = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0};
      chk_log("t3", e);

      // Backpressure for 5 cycles mid-packet.
      @(negedge i_clk);
      push_pkt(0, 6, 1);
      n = 0;
      while (!o_stb && n < 20) begin @(negedge i_clk); n++; end
      chk("t4_start", 64'(n < 20), 64'd1);
      @(negedge i_clk);
      busy_force = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         chk($sformatf("t4_a_busy%0d", i), 64'(o_a_busy), 64'd1);
         chk($sformatf("t4_stb%0d", i), 64'(o_stb), 64'd1);
      end
      busy_force = 0;
      wait_drain("t4");

      // Source gap: A pauses after its first word while B waits.
      @(negedge i_clk);
      src_log.delete();
      push_pkt(0, 1, 0);
      g.w = '0; g.l = 0; g.g = 1;
      qa.push_back(g);
      push_pkt(0, 2, 1);
      @(negedge i_clk);
      push_pkt(1, 2, 1);
      wait_drain("t5");
      e = '{0, 1, 1, 0, 0};
      chk_log("t5", e);
      chk("t5_rr", 64'(dut.rr_q), 64'd1);

      // Reset during A's second word; A must be preferred afterwards.
      @(negedge i_clk);
      push_pkt(0, 3, 1);
      n = 0;
      while (!o_stb && n < 20) begin @(negedge i_clk); n++; end
      chk("t6_start", 64'(n < 20), 64'd1);
      @(posedge i_clk); #2;
      i_reset = 1;
      push_pkt(1, 2, 1);
      @(posedge i_clk); #1 i_reset = 0;
      @(negedge i_clk);
      chk("t6_stb_after_rst", 64'(o_stb), 64'd0);
      chk("t6_gstate_after_rst", 64'(dut.gstate_q), 64'd0);
      chk("t6_rr_after_rst", 64'(dut.rr_q), 64'd0);
      #1 src_log.delete();
      wait_drain("t6");
      e = '{0, 1, 1};
      chk_log("t6", e);

      // Randomized traffic with gaps, mixed last usage and random stalls.
      rand_mode = 1;
      for (int i = 0; i < 800; i++) begin
         @(negedge i_clk);
         if (qa.size() < 8 && $urandom_range(0, 5) == 0)
            push_pkt(0, $urandom_range(1, 7), $urandom_range(0, 3) != 0);
         if (qb.size() < 8 && $urandom_range(0, 5) == 0)
            push_pkt(1, $urandom_range(1, 7), $urandom_range(0, 3) != 0);
      end
      rand_mode = 0;
      wait_drain("rand");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/exbus_arb.md
# exbus_arb

Two-input, packet-aware arbiter for the exbus outgoing 35-bit word stream. It merges a bus-response source (A) and a console/stream source (B) into one registered word stream that feeds the idle/status inserter ahead of the byte encoder. Arbitration is round-robin. A grant is held for a whole packet, up to a burst limit, so that a source's multi-word sequences are never interleaved with the other source's words.

## Interface

- LGBURST, 4: log2 of the maximum number of words accepted per grant (default 16).
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  reset, synchronous, active-high; clock i_clk.
- i_a_stb  in  1  source A has a word valid.
- i_a_word  in  35  source A word. Bits [34:33] are the word type, passed through unmodified.
- i_a_last  in  1  final word of source A's current packet; qualified by i_a_stb.
- o_a_busy  out  1  source A word not accepted this cycle (combinational).
- i_b_stb, i_b_word, i_b_last, o_b_busy: same as the A ports, for source B.
- o_stb  out  1  output word valid.
- o_word  out  35  output word.
- o_src  out  1  source of o_word: 0 = A, 1 = B.
- i_busy  in  1  downstream stall.

## Operation

- State: `gstate` ∈ {IDLE, GNT_A, GNT_B}; round-robin pointer `rr` (0 = A preferred); burst counter `bcnt` of LGBURST bits.
- Output ready: `ordy = !o_stb || !i_busy`.
- Accept A: `acc_a = (gstate==GNT_A) && i_a_stb && ordy`. Accept B is the same with GNT_B and i_b_stb.
- Busy outputs: `o_a_busy = !acc_a`, `o_b_busy = !acc_b`. Busy is high whenever a source is not granted, including in IDLE.
- IDLE:
  - Only A requesting → GNT_A. Only B requesting → GNT_B.
  - Both requesting → GNT_A if rr==0, else GNT_B.
  - Neither requesting → stay IDLE.
  - `bcnt` is cleared on every transition out of IDLE.
- GNT_x:
  - On each accept: o_word ← i_x_word, o_src ← x, o_stb ← 1, `bcnt` ← `bcnt`+1.
  - Release to IDLE when any of these holds:
    - accept with i_x_last;
    - accept with `bcnt` == 2^LGBURST−1;
    - i_x_stb low (a gap releases the grant immediately).
  - On release, rr ← 1 if x was A, rr ← 0 if x was B (the other source is preferred next).
- No accept and !i_busy → o_stb ← 0. o_word and o_src hold their values.
- While `o_stb && i_busy`: o_stb, o_word and o_src are stable.
- Reset values: o_stb=0, o_word=0, o_src=0, gstate=IDLE, rr=0, bcnt=0.
- Reset mid-packet: the grant is abandoned, the pending o_word is dropped, and source A is preferred next.

## Timing

- Arbitration costs one cycle. A request seen in IDLE at cycle n registers the grant at n+1. The first accept can occur at n+1 and o_stb rises at n+2.
- Within a grant, throughput is one word per clock while i_busy=0. Latency from accept to o_stb is 1 cycle.
- A release at the accept of word k means the next source's first word is accepted no earlier than 2 cycles later (IDLE, then grant).
- Simultaneous release and a new request from the other source: the other source wins the following IDLE evaluation.
- A burst-limit release while the same source still has stb high and no last: that source re-requests. It loses to the other source if the other is requesting; otherwise it is re-granted after 1 IDLE cycle.
- i_busy high during a grant: accepts stall, o_a_busy/o_b_busy stay high, and the grant and `bcnt` hold.
- When the source's final word was accepted with i_x_last while i_busy was low, the grant still releases.

## Test plan

- **Single A packet.** A sends 3 words (last on the third), i_busy=0. Required: o_stb high for 3 consecutive cycles starting 2 cycles after the first stb; o_src=0; words in order; gstate returns to IDLE.
- **Contention round-robin.** A and B each hold a 2-word packet, both stb high from reset release. Required: A's 2 words, one idle output cycle, then B's 2 words with o_src=1; rr ends at 0.
- **Burst limit.** LGBURST=2. A streams 10 words with no last while B requests. Required: A 4 words, B's packet, A 4 words, and so on; never more than 4 consecutive A words.
- **Backpressure.** i_busy high for 5 cycles mid-packet. Required: o_word and o_src stable, o_a_busy high, no word lost or duplicated after release.
- **Source gap.** A drops stb after word 1 of 3 while B is waiting. Required: grant moves to B; A's remaining words follow B's packet.
- **Reset mid-packet.** i_reset asserted during A's word 2. Required: next cycle o_stb=0, gstate=IDLE; A and B both requesting afterwards → A granted first.
